// File: rtl/alu_mul_seq_if.sv
// alu_mul_seq_if: request, shared-ALU borrow and result signals of the multiply sequencer
interface alu_mul_seq_if;
    logic        Start;
    logic        Word;
    logic        Kill;
    logic [63:0] MulOpA;
    logic [63:0] MulOpB;
    logic [63:0] AluResult;
    logic [63:0] AluSrcA;
    logic [63:0] AluSrcB;
    logic [4:0]  AluControl;
    logic        Busy;
    logic        Done;
    logic [63:0] Product;

    modport master (
        output Start, Word, Kill, MulOpA, MulOpB, AluResult,
        input  AluSrcA, AluSrcB, AluControl, Busy, Done, Product
    );

    modport slave (
        input  Start, Word, Kill, MulOpA, MulOpB, AluResult,
        output AluSrcA, AluSrcB, AluControl, Busy, Done, Product
    );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative MUL/MULW via shift-add on the shared ALU, with ADDW pass for word results
module alu_mul_seq (
    input  logic         clk,
    input  logic         rst_n,
    alu_mul_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state, state_nxt;
    logic [63:0] acc, acc_nxt, mcand, mult, product;
    logic [6:0]  cnt;
    logic        word_r;
    logic        last;

    // exit as soon as no multiplier bits remain, or at the iteration limit
    assign last = (mult >> 1) == 64'd0 || cnt == (word_r ? 7'd31 : 7'd63);
    assign bus.Product = product;

    always_comb begin
        state_nxt      = state;
        acc_nxt        = acc;
        bus.AluSrcA    = '0;
        bus.AluSrcB    = '0;
        bus.AluControl = '0;
        bus.Busy       = 1'b0;
        bus.Done       = 1'b0;
        case (state)
            IDLE: state_nxt = bus.Start ? RUN : IDLE;
            RUN: begin
                bus.AluSrcA = acc;
                bus.AluSrcB = mcand;
                bus.Busy    = 1'b1;
                acc_nxt     = mult[0] ? bus.AluResult : acc;
                state_nxt   = bus.Kill ? IDLE : !last ? RUN : word_r ? FIX : DONE;
            end
            FIX: begin
                bus.AluSrcA    = acc;
                bus.AluControl = 5'b01000;
                bus.Busy       = 1'b1;
                acc_nxt        = bus.AluResult;
                state_nxt      = bus.Kill ? IDLE : DONE;
            end
            default: begin
                bus.Done  = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            mcand   <= '0;
            mult    <= '0;
            cnt     <= '0;
            word_r  <= 1'b0;
            product <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.Start) begin
                acc    <= '0;
                cnt    <= '0;
                word_r <= bus.Word;
                mcand  <= bus.Word ? {32'b0, bus.MulOpA[31:0]} : bus.MulOpA;
                mult   <= bus.Word ? {32'b0, bus.MulOpB[31:0]} : bus.MulOpB;
            end else if (state == RUN) begin
                acc   <= acc_nxt;
                mcand <= mcand << 1;
                mult  <= mult >> 1;
                cnt   <= cnt + 7'd1;
            end else if (state == FIX) begin
                acc <= acc_nxt;
            end
            // DONE is only entered from RUN/FIX, so this fires once per completed op
            if (state_nxt == DONE)
                product <= acc_nxt;
        end
    end
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed bench with ALU model and product scoreboard for alu_mul_seq
module tb_alu_mul_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_mul_seq_if bus ();
    alu_mul_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [63:0] alu_sum;
    assign alu_sum = bus.AluSrcA + bus.AluSrcB;
    assign bus.AluResult = bus.AluControl == 5'b01000 ? {{32{alu_sum[31]}}, alu_sum[31:0]} :
                           bus.AluControl == 5'b00000 ? alu_sum : 64'd0;

    int errors = 0;
    int checks = 0;
    logic [63:0] q[$];
    logic [63:0] last_prod = 64'd0;
    logic [63:0] ra, rb;
    int dones;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int eff_n(input logic [63:0] b);
        int n = 1;
        for (int i = 0; i < 64; i++) if (b[i]) n = i + 1;
        return n;
    endfunction

    // Drive one op at a negedge; c counts cycles after the issuing cycle
    task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic w, input bit hold, input int lat, input bit noise);
        logic [63:0] be, p, exp;
        int n, f, busy_cnt, done_cyc;
        be  = w ? {32'b0, b[31:0]} : b;
        p   = a * b;
        exp = w ? {{32{p[31]}}, p[31:0]} : p;
        n   = eff_n(be);
        f   = w ? 1 : 0;
        q.push_back(exp);
        bus.Start  = 1'b1;
        bus.Word   = w;
        bus.MulOpA = a;
        bus.MulOpB = b;
        busy_cnt = 0;
        done_cyc = 0;
        for (int c = 1; c <= 200 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (bus.Busy) busy_cnt++;
            if (bus.Busy && !hold) bus.Start = 1'b0;
            if (noise && c == 3) begin
                bus.Start  = 1'b1;
                bus.MulOpA = ~a;
                bus.MulOpB = '1;
                bus.Word   = ~w;
            end
            if (noise && c == 4) bus.Start = 1'b0;
            if (bus.Done) begin
                done_cyc = c;
                if (noise) bus.Start = 1'b1;
            end
        end
        chk({tag, " done_cycle"}, 64'(done_cyc), 64'(lat + n + f + 1));
        chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'(n + f));
        chk({tag, " product"}, bus.Product, q.pop_front());
        last_prod = exp;
        if (!hold) begin
            @(negedge clk);
            if (noise) chk({tag, " start_in_done_ignored"}, 64'(bus.Busy), 64'd0);
            bus.Start = 1'b0;
        end
    endtask

    initial begin
        bus.Start  = 1'b0;
        bus.Word   = 1'b0;
        bus.Kill   = 1'b0;
        bus.MulOpA = '0;
        bus.MulOpB = '0;
        repeat (2) @(negedge clk);
        chk("rst Busy", 64'(bus.Busy), 64'd0);
        chk("rst Done", 64'(bus.Done), 64'd0);
        chk("rst Product", bus.Product, 64'd0);
        chk("rst AluSrcA", bus.AluSrcA, 64'd0);
        chk("rst AluSrcB", bus.AluSrcB, 64'd0);
        chk("rst AluControl", 64'(bus.AluControl), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("mul_3x5", 64'd3, 64'd5, 1'b0, 1'b0, 0, 1'b0);
        do_op("mul_full", '1, '1, 1'b0, 1'b0, 0, 1'b0);
        do_op("mulw_sext", 64'h7FFF_FFFF, 64'hFFFF_FFFF_0000_0002, 1'b1, 1'b0, 0, 1'b0);
        do_op("mul_zero", 64'h1234, 64'd0, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom} >> $urandom_range(0, 63);
            do_op("rand", ra, rb, i[0], 1'b0, 0, 1'b0);
        end
        do_op("noise", 64'hABCD, 64'h00F0, 1'b0, 1'b0, 0, 1'b1);
        do_op("b2b_first", 64'd7, 64'd9, 1'b0, 1'b1, 0, 1'b0);
        do_op("b2b_second", 64'h1_0000_0001, 64'hFFFF_0003, 1'b1, 1'b0, 1, 1'b0);

        // Kill at cycle 10 of a 64-cycle op
        bus.Start  = 1'b1;
        bus.Word   = 1'b0;
        bus.MulOpA = 64'd5;
        bus.MulOpB = 64'h8000_0000_0000_0000;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) bus.Start = 1'b0;
            if (c == 10) bus.Kill = 1'b1;
        end
        @(negedge clk);
        bus.Kill = 1'b0;
        chk("kill Busy", 64'(bus.Busy), 64'd0);
        chk("kill Done", 64'(bus.Done), 64'd0);
        chk("kill Product", bus.Product, last_prod);
        dones = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.Done) dones++;
        end
        chk("kill no_done", 64'(dones), 64'd0);

        // Reset at cycle 10 of the same op
        bus.Start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) bus.Start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst Busy", 64'(bus.Busy), 64'd0);
        chk("midrst Done", 64'(bus.Done), 64'd0);
        chk("midrst Product", bus.Product, 64'd0);
        chk("midrst AluSrcB", bus.AluSrcB, 64'd0);
        chk("midrst AluControl", 64'(bus.AluControl), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op("after_rst", 64'd12, 64'd12, 1'b0, 1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "timeout");
    end
endmodule
